// File: rtl/matmul_compute.sv
// Purpose : matrix-multiply compute stage. It walks C[m][n] in row-major order and
//           reads A[m][k] and B[k][n] one pair per cycle from the input memory stage.
//           A single signed MAC accumulates each dot product, and the result is
//           streamed out on an AXI-Stream master.
// Latency : first read address is presented the cycle after start. TVALID rises
//           Kr+2 edges after start, and again Kr+2 edges after each accepted beat.
// Backpr. : one result is held in flight. While TVALID is high and TREADY is low,
//           TDATA/TVALID stay stable and no reads are issued.
// Ports   : clk/reset (sync, active-high); matrices_loaded/K come from the input stage;
//           A_read_addr/A_data and B_read_addr/B_data are the memory read ports
//           (data returns 1 cycle after the address); AXIS_* is the result stream;
//           compute_finished pulses for one cycle after the last beat is accepted.
module matmul_compute #(
    parameter  int INW         = 12,
    parameter  int M           = 7,
    parameter  int N           = 9,
    parameter  int MAXK        = 8,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int A_ADDR_BITS = $clog2(M * MAXK),
    localparam int B_ADDR_BITS = $clog2(MAXK * N),
    localparam int OUTW        = 2 * INW + $clog2(MAXK)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          matrices_loaded,
    input  logic [K_BITS-1:0]             K,
    output logic [A_ADDR_BITS-1:0]        A_read_addr,
    input  logic signed [INW-1:0]         A_data,
    output logic [B_ADDR_BITS-1:0]        B_read_addr,
    input  logic signed [INW-1:0]         B_data,
    output logic                          compute_finished,
    output logic signed [OUTW-1:0]        AXIS_TDATA,
    output logic                          AXIS_TVALID,
    input  logic                          AXIS_TREADY
);

    localparam int M_BITS = (M > 1) ? $clog2(M) : 1;
    localparam int N_BITS = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUT,
        ST_DONE,
        ST_WAIT_CLR
    } state_t;

    state_t                  state_q, state_d;
    logic [K_BITS-1:0]       kr_q, kr_d;
    logic [M_BITS-1:0]       m_q, m_d;
    logic [N_BITS-1:0]       n_q, n_d;
    logic [K_BITS-1:0]       k_q, k_d;
    logic signed [OUTW-1:0]  acc_q, acc_d;
    logic                    rd_vld_q, rd_vld_d;   // a read was issued last cycle, so its data is on A_data/B_data now
    logic signed [OUTW-1:0]  tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;

    logic signed [2*INW-1:0] prod;

    // The full-width product is then sign-extended into the accumulator.
    assign prod = A_data * B_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            kr_q     <= '0;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            rd_vld_q <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            kr_q     <= kr_d;
            m_q      <= m_d;
            n_q      <= n_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            rd_vld_q <= rd_vld_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        kr_d        = kr_q;
        m_d         = m_q;
        n_d         = n_q;
        k_d         = k_q;
        acc_d       = acc_q;
        rd_vld_d    = 1'b0;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        A_read_addr = '0;
        B_read_addr = '0;

        // Data from last cycle's read is valid now, regardless of the current state.
        if (rd_vld_q) begin
            acc_d = acc_q + OUTW'(prod);
        end

        case (state_q)
            ST_IDLE: begin
                if (matrices_loaded) begin
                    kr_d  = K;
                    m_d   = '0;
                    n_d   = '0;
                    k_d   = '0;
                    acc_d = '0;
                    if (K == '0) begin
                        // An empty dot product is zero, so nothing needs to be read.
                        tdata_d  = '0;
                        tvalid_d = 1'b1;
                        state_d  = ST_OUT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (kr_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    A_read_addr = A_ADDR_BITS'(m_q) * A_ADDR_BITS'(kr_q) + A_ADDR_BITS'(k_q);
                    B_read_addr = B_ADDR_BITS'(k_q) * B_ADDR_BITS'(N) + B_ADDR_BITS'(n_q);
                    rd_vld_d    = 1'b1;
                    k_d         = k_q + K_BITS'(1);
                    if (k_q == kr_q - K_BITS'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // The first cycle adds the last product. The next cycle registers the total.
                if (!rd_vld_q) begin
                    tdata_d  = acc_q;
                    tvalid_d = 1'b1;
                    state_d  = ST_OUT;
                end
            end

            ST_OUT: begin
                if (AXIS_TREADY) begin
                    tvalid_d = 1'b0;
                    acc_d    = '0;
                    k_d      = '0;
                    if ((m_q == M_BITS'(M - 1)) && (n_q == N_BITS'(N - 1))) begin
                        state_d = ST_DONE;
                    end else begin
                        if (n_q == N_BITS'(N - 1)) begin
                            n_d = '0;
                            m_d = m_q + M_BITS'(1);
                        end else begin
                            n_d = n_q + N_BITS'(1);
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_WAIT_CLR;
            end

            ST_WAIT_CLR: begin
                // A stale matrices_loaded from the finished run must not restart the engine.
                if (!matrices_loaded) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign AXIS_TDATA       = tdata_q;
    assign AXIS_TVALID      = tvalid_q;
    assign compute_finished = (state_q == ST_DONE);

endmodule

// File: tb/tb_matmul_compute.sv
// Purpose : self-checking bench for matmul_compute. Random and directed matrices are used.
//           A behavioural matrix product feeds a scoreboard queue.
// Latency : not applicable (testbench).
// Backpr. : TREADY is driven always-high, randomly toggled, or forced low.
module tb_matmul_compute;

    localparam int INW         = 12;
    localparam int M           = 7;
    localparam int N           = 9;
    localparam int MAXK        = 8;
    localparam int K_BITS      = $clog2(MAXK + 1);
    localparam int A_ADDR_BITS = $clog2(M * MAXK);
    localparam int B_ADDR_BITS = $clog2(MAXK * N);
    localparam int OUTW        = 2 * INW + $clog2(MAXK);

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   matrices_loaded;
    logic [K_BITS-1:0]      K;
    logic [A_ADDR_BITS-1:0] A_read_addr;
    logic signed [INW-1:0]  A_data = '0;
    logic [B_ADDR_BITS-1:0] B_read_addr;
    logic signed [INW-1:0]  B_data = '0;
    logic                   compute_finished;
    logic signed [OUTW-1:0] AXIS_TDATA;
    logic                   AXIS_TVALID;
    logic                   AXIS_TREADY = 1'b0;

    matmul_compute #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
        .clk              (clk),
        .reset            (reset),
        .matrices_loaded  (matrices_loaded),
        .K                (K),
        .A_read_addr      (A_read_addr),
        .A_data           (A_data),
        .B_read_addr      (B_read_addr),
        .B_data           (B_data),
        .compute_finished (compute_finished),
        .AXIS_TDATA       (AXIS_TDATA),
        .AXIS_TVALID      (AXIS_TVALID),
        .AXIS_TREADY      (AXIS_TREADY)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                   last;
        logic signed [OUTW-1:0] d;
    } exp_t;

    exp_t sb[$];

    int total    = 0;
    int bad      = 0;
    int beats    = 0;
    int rdy_mode = 2;        // 0: always ready, 1: random, 2: forced low
    bit chk_zero = 1'b0;
    bit addr_bad = 1'b0;

    logic signed [INW-1:0] amem [2**A_ADDR_BITS];
    logic signed [INW-1:0] bmem [2**B_ADDR_BITS];
    int a_m [M][MAXK];
    int b_m [MAXK][N];

    // Synchronous read memory: data follows the address by one cycle.
    always @(posedge clk) begin
        A_data <= amem[A_read_addr];
        B_data <= bmem[B_read_addr];
    end

    always begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       AXIS_TREADY = 1'b1;
            1:       AXIS_TREADY = 1'($urandom_range(0, 1));
            default: AXIS_TREADY = 1'b0;
        endcase
    end

    // Monitor: runs on the falling edge. A beat is seen here when it will complete on the next rising edge.
    logic                   prev_vld = 1'b0;
    logic                   prev_rdy = 1'b0;
    logic                   prev_rst = 1'b1;
    logic signed [OUTW-1:0] prev_dat = '0;
    bit                     exp_cf   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_rst = 1'b1;
            exp_cf   = 1'b0;
        end else begin
            if (chk_zero && (A_read_addr != '0 || B_read_addr != '0)) addr_bad = 1'b1;
            if (!prev_rst && prev_vld && !prev_rdy) begin
                total++;
                if (!AXIS_TVALID || AXIS_TDATA !== prev_dat) begin
                    bad++;
                    $display("FAIL stall_hold: got vld=%0b data=%0d, required vld=1 data=%0d",
                             AXIS_TVALID, AXIS_TDATA, prev_dat);
                end
            end
            if (compute_finished || exp_cf) begin
                total++;
                if (compute_finished !== exp_cf) begin
                    bad++;
                    $display("FAIL compute_finished: got %0b, required %0b", compute_finished, exp_cf);
                end
            end
            exp_cf = 1'b0;
            if (AXIS_TVALID && AXIS_TREADY) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got data=%0d, required no beat", AXIS_TDATA);
                end else begin
                    e = sb.pop_front();
                    if (AXIS_TDATA !== e.d) begin
                        bad++;
                        $display("FAIL beat_data: got %0d, required %0d (beat %0d)",
                                 AXIS_TDATA, e.d, beats);
                    end
                    exp_cf = e.last;
                    beats++;
                end
            end
            prev_rst = 1'b0;
        end
        prev_vld = AXIS_TVALID;
        prev_rdy = AXIS_TREADY;
        prev_dat = AXIS_TDATA;
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // fill: 0 A=1/B=2, 1 A=B=-2048, 2 A=-2048/B=2047, 3 A=m+k/B=n-k, 4 random
    task automatic run(input int kk, input int fill, input int rmode, input bit measure);
        longint s;
        int     lat;
        exp_t   e;
        rdy_mode = rmode;
        for (int m = 0; m < M; m++)
            for (int k = 0; k < MAXK; k++)
                case (fill)
                    0:       a_m[m][k] = 1;
                    1, 2:    a_m[m][k] = -2048;
                    3:       a_m[m][k] = m + k;
                    default: a_m[m][k] = int'($urandom_range(0, 4095)) - 2048;
                endcase
        for (int k = 0; k < MAXK; k++)
            for (int n = 0; n < N; n++)
                case (fill)
                    0:       b_m[k][n] = 2;
                    1:       b_m[k][n] = -2048;
                    2:       b_m[k][n] = 2047;
                    3:       b_m[k][n] = n - k;
                    default: b_m[k][n] = int'($urandom_range(0, 4095)) - 2048;
                endcase
        for (int i = 0; i < 2**A_ADDR_BITS; i++) amem[i] = '0;
        for (int i = 0; i < 2**B_ADDR_BITS; i++) bmem[i] = '0;
        for (int m = 0; m < M; m++)
            for (int k = 0; k < kk; k++) amem[m*kk + k] = a_m[m][k][INW-1:0];
        for (int k = 0; k < kk; k++)
            for (int n = 0; n < N; n++) bmem[k*N + n] = b_m[k][n][INW-1:0];
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++) begin
                s = 0;
                for (int k = 0; k < kk; k++) s += longint'(a_m[m][k]) * longint'(b_m[k][n]);
                e.d    = s[OUTW-1:0];
                e.last = (m == M-1) && (n == N-1);
                sb.push_back(e);
            end
        @(posedge clk);
        #1;
        K = K_BITS'(kk);
        matrices_loaded = 1'b1;
        if (measure) begin
            @(posedge clk);
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!AXIS_TVALID && lat < 40);
            chk("first_tvalid_latency", lat, kk + 2);
        end
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!compute_finished && c < 6000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({name, "_finished"}, compute_finished, 1);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic release_loaded();
        matrices_loaded = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int base;
        reset = 1'b1;
        matrices_loaded = 1'b0;
        K = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", AXIS_TVALID, 0);
        chk("rst_tdata", AXIS_TDATA, 0);
        chk("rst_finished", compute_finished, 0);
        chk("rst_a_addr", A_read_addr, 0);
        chk("rst_b_addr", B_read_addr, 0);
        reset = 1'b0;

        run(3, 0, 0, 1'b1);
        wait_done("ones_twos");
        release_loaded();

        run(8, 1, 0, 1'b0);
        wait_done("neg_neg_max");
        release_loaded();
        run(8, 2, 0, 1'b0);
        wait_done("neg_pos_max");
        release_loaded();

        // Changing K after start must not affect the run.
        run(2, 3, 1, 1'b0);
        @(posedge clk);
        #1;
        K = K_BITS'(7);
        wait_done("ramp_stall");
        release_loaded();

        addr_bad = 1'b0;
        chk_zero = 1'b1;
        run(0, 4, 1, 1'b0);
        wait_done("k_zero");
        chk("k_zero_addr_nonzero", addr_bad, 0);
        chk_zero = 1'b0;
        release_loaded();

        // Reset while the 10th element is in progress, then start a fresh run.
        run(5, 4, 0, 1'b0);
        base = beats;
        c = 0;
        while (beats - base < 9 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("beats_before_reset", beats - base, 9);
        rdy_mode = 2;
        reset = 1'b1;
        matrices_loaded = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_tvalid", AXIS_TVALID, 0);
        chk("midrst_tdata", AXIS_TDATA, 0);
        chk("midrst_finished", compute_finished, 0);
        chk("midrst_a_addr", A_read_addr, 0);
        chk("midrst_b_addr", B_read_addr, 0);
        sb.delete();
        reset = 1'b0;
        run(4, 4, 0, 1'b0);
        wait_done("after_reset");
        release_loaded();

        // matrices_loaded stays high after finish: the engine must wait for it to drop.
        run(2, 4, 1, 1'b0);
        wait_done("stale_first");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stale_no_tvalid", AXIS_TVALID, 0);
            chk("stale_no_a_read", A_read_addr, 0);
            chk("stale_no_b_read", B_read_addr, 0);
        end
        matrices_loaded = 1'b0;
        run(3, 4, 1, 1'b0);
        wait_done("stale_second");
        release_loaded();

        for (int i = 0; i < 3; i++) begin
            run(int'($urandom_range(1, MAXK)), 4, 1, 1'b0);
            wait_done("random_k");
            release_loaded();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
